// File: rtl/xresult_fmt.sv
// xresult_fmt
//   Converts the calculator's W-bit two's-complement result into a sign flag
//   plus ND BCD digits, then replays the value as a key-code stream
//   (10 plus / 11 minus, digits 0-9 MSD first, 14 enter). The operation
//   block can consume that stream to chain the result as its next operand.
//
//   Conversion is a sequential shift-add-3 (double dabble) engine, one bit
//   per clock. The stream uses a valid/ready handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       conversion request, sampled only while idle
//   data_in     signed value to convert, captured on the start-accept edge
//   busy        high from the cycle after accept until enter (14) transfers
//   done        one-cycle pulse when negative/digits are updated
//   negative    sign of the captured value
//   digits      ND BCD digits, most-significant nibble = most-significant digit
//   code        current stream key code
//   code_valid  code is valid
//   code_ready  consumer accepts code
module xresult_fmt #(
    parameter int unsigned W        = 11,
    parameter int unsigned ND       = 4,
    parameter bit          SUPPRESS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    data_in,
    output logic            busy,
    output logic            done,
    output logic            negative,
    output logic [4*ND-1:0] digits,
    output logic [3:0]      code,
    output logic            code_valid,
    input  logic            code_ready
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned IW = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [3:0] CodePlus  = 4'd10;
    localparam logic [3:0] CodeMinus = 4'd11;
    localparam logic [3:0] CodeEnter = 4'd14;

    typedef enum logic [1:0] {StIdle, StConv, StEmit} state_t;
    typedef enum logic [1:0] {PhSign, PhDigit, PhEnter} phase_t;

    state_t          state_q;
    phase_t          phase_q;
    logic [4*ND-1:0] bcd_q;
    logic [W-1:0]    mag_q;
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic [IW-1:0]   idx_q;

    logic [4*ND-1:0] bcd_adj;
    logic [4*ND-1:0] bcd_next;
    logic [W-1:0]    mag_next;
    logic [IW-1:0]   first_idx;
    logic [3:0]      cur_nib;
    logic [3:0]      nxt_nib;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift the
    // whole {bcd, mag} register left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_next, mag_next} = {bcd_adj, mag_q} << 1;
    end

    // Index of the first digit to send. With suppression this is the highest
    // non-zero nibble of the final result (0 when the value is zero, so a
    // single "0" is still sent). Evaluated on the final iteration's result.
    always_comb begin
        first_idx = '0;
        if (SUPPRESS) begin
            for (int unsigned i = 0; i < ND; i++) begin
                if (bcd_next[4*i +: 4] != 4'd0) begin
                    first_idx = IW'(i);
                end
            end
        end else begin
            first_idx = IW'(ND - 1);
        end
    end

    // Current digit and the one below it, selected from the held result.
    always_comb begin
        cur_nib = '0;
        nxt_nib = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (IW'(i) == idx_q) begin
                cur_nib = digits[4*i +: 4];
            end
            if (IW'(i) == idx_q - IW'(1)) begin
                nxt_nib = digits[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= PhSign;
            bcd_q      <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            idx_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            negative   <= 1'b0;
            digits     <= '0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sign_q  <= data_in[W-1];
                        // -(-2^(W-1)) wraps to 2^(W-1), which is the correct
                        // unsigned magnitude, so no overflow handling needed.
                        mag_q   <= data_in[W-1] ? (~data_in + W'(1)) : data_in;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(W);
                        busy    <= 1'b1;
                        state_q <= StConv;
                    end
                end

                StConv: begin
                    bcd_q <= bcd_next;
                    mag_q <= mag_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        negative <= sign_q;
                        digits   <= bcd_next;
                        idx_q    <= first_idx;
                        done     <= 1'b1;
                        state_q  <= StEmit;
                    end
                end

                StEmit: begin
                    if (!code_valid) begin
                        // First EMIT cycle: present the sign code.
                        code_valid <= 1'b1;
                        code       <= negative ? CodeMinus : CodePlus;
                        phase_q    <= PhSign;
                    end else if (code_ready) begin
                        unique case (phase_q)
                            PhSign: begin
                                code    <= cur_nib;
                                phase_q <= PhDigit;
                            end
                            PhDigit: begin
                                if (idx_q == '0) begin
                                    code    <= CodeEnter;
                                    phase_q <= PhEnter;
                                end else begin
                                    code  <= nxt_nib;
                                    idx_q <= idx_q - IW'(1);
                                end
                            end
                            PhEnter: begin
                                code       <= '0;
                                code_valid <= 1'b0;
                                busy       <= 1'b0;
                                state_q    <= StIdle;
                            end
                            default: begin
                                phase_q <= PhSign;
                            end
                        endcase
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xresult_fmt.sv
// Bench for xresult_fmt. Two instances share stimulus: one with leading-zero
// suppression, one sending all digits. A decimal model (division/modulo and a
// queue of expected key codes) is checked against both every cycle.
module tb_xresult_fmt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        code_ready = 1'b0;
    logic [10:0] data_in = '0;

    logic        busy0, done0, neg0, valid0;
    logic [15:0] dig0;
    logic [3:0]  code0;
    logic        busy1, done1, neg1, valid1;
    logic [15:0] dig1;
    logic [3:0]  code1;

    xresult_fmt #(.W(11), .ND(4), .SUPPRESS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy0), .done(done0), .negative(neg0), .digits(dig0),
        .code(code0), .code_valid(valid0), .code_ready(code_ready)
    );

    xresult_fmt #(.W(11), .ND(4), .SUPPRESS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy1), .done(done1), .negative(neg1), .digits(dig1),
        .code(code1), .code_valid(valid1), .code_ready(code_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- model ----------------
    int unsigned tmpq[$];
    logic        m_neg;
    logic [15:0] m_dig;

    function automatic void model(input logic [10:0] v, input bit supp);
        int val, mag, st;
        int d[4];
        val   = $signed(v);
        m_neg = (val < 0);
        mag   = m_neg ? -val : val;
        m_dig = '0;
        for (int i = 0; i < 4; i++) begin
            d[i] = (mag / (10 ** i)) % 10;
            m_dig[4*i +: 4] = 4'(d[i]);
        end
        tmpq.delete();
        tmpq.push_back(m_neg ? 11 : 10);
        st = 3;
        if (supp) while (st > 0 && d[st] == 0) st--;
        for (int i = st; i >= 0; i--) tmpq.push_back(d[i]);
        tmpq.push_back(14);
    endfunction

    function automatic logic [31:0] pack_q();
        logic [31:0] v;
        v = '0;
        foreach (tmpq[i]) v = (v << 4) | tmpq[i];
        return v;
    endfunction

    // ---------------- per-DUT expectation state ----------------
    int unsigned q0[$];
    int unsigned q1[$];
    logic        exp_neg;
    logic [15:0] exp_dig;
    int          acc_cyc = -100;
    bit          pend[2];
    int          done_cyc[2];
    bit          prev_valid[2];
    logic [3:0]  prev_code[2];
    bit          prev_xfer[2];
    bit          idle_exp[2];
    bit          prev_ready = 1'b0;

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int unsigned qfront(input int d);
        if (qsize(d) == 0) return 99;
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int unsigned qpop(input int d);
        return (d == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic clear_state();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            pend[d] = 0; done_cyc[d] = -100; prev_valid[d] = 0;
            prev_code[d] = '0; prev_xfer[d] = 0; idle_exp[d] = 0;
        end
        prev_ready = 0;
    endtask

    task automatic cmp(input int d, input logic dn, input logic ng, input logic [15:0] dg,
                       input logic [3:0] cd, input logic vl, input logic bs);
        int unsigned e;
        if (pend[d] && cyc == acc_cyc) check($sformatf("d%0d_busy_rise", d), bs, 1);
        if (dn) begin
            check($sformatf("d%0d_done_expected", d), pend[d], 1);
            check($sformatf("d%0d_done_latency", d), cyc - acc_cyc, 11);
            check($sformatf("d%0d_negative", d), ng, exp_neg);
            check($sformatf("d%0d_digits", d), dg, exp_dig);
            pend[d] = 0;
            done_cyc[d] = cyc;
        end
        if (cyc == done_cyc[d] + 1) begin
            check($sformatf("d%0d_valid_after_done", d), vl, 1);
            check($sformatf("d%0d_first_code", d), cd, qfront(d));
        end
        if (prev_valid[d] && !prev_ready) begin
            check($sformatf("d%0d_hold_valid", d), vl, 1);
            check($sformatf("d%0d_hold_code", d), cd, prev_code[d]);
        end
        if (prev_xfer[d] && qsize(d) > 0) check($sformatf("d%0d_no_bubble", d), vl, 1);
        if (idle_exp[d]) begin
            check($sformatf("d%0d_busy_fall", d), bs, 0);
            check($sformatf("d%0d_valid_fall", d), vl, 0);
            idle_exp[d] = 0;
        end
        if (vl && code_ready) begin
            if (qsize(d) == 0) begin
                check($sformatf("d%0d_extra_code", d), {28'd0, cd}, 32'hFF);
            end else begin
                e = qpop(d);
                check($sformatf("d%0d_code", d), cd, e);
                if (qsize(d) == 0) idle_exp[d] = 1;
            end
        end
        prev_valid[d] = vl;
        prev_code[d]  = cd;
        prev_xfer[d]  = vl && code_ready;
    endtask

    initial begin
        clear_state();
        forever begin
            @(negedge clk);
            if (!rst) begin
                cmp(0, done0, neg0, dig0, code0, valid0, busy0);
                cmp(1, done1, neg1, dig1, code1, valid1, busy1);
                prev_ready = code_ready;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic launch(input logic [10:0] v);
        model(v, 1'b0);
        q1 = tmpq;
        model(v, 1'b1);
        q0 = tmpq;
        exp_neg = m_neg;
        exp_dig = m_dig;
        @(posedge clk);
        #1;
        data_in = v;
        start   = 1'b1;
        acc_cyc = cyc + 1;
        pend[0] = 1;
        pend[1] = 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_wait(input string name);
        int k;
        k = 0;
        while ((busy0 || busy1 || pend[0] || pend[1]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, (k < 200), 1);
        check({name, "_done_seen"}, {pend[1], pend[0]}, 0);
        check({name, "_q0_empty"}, q0.size(), 0);
        check({name, "_q1_empty"}, q1.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {busy1, busy0}, 0);
        check({name, "_done"}, {done1, done0}, 0);
        check({name, "_neg"}, {neg1, neg0}, 0);
        check({name, "_digits"}, {dig1, dig0}, 0);
        check({name, "_code"}, {code1, code0}, 0);
        check({name, "_valid"}, {valid1, valid0}, 0);
    endtask

    initial begin
        int k;
        // Hand-computed pins on the model itself.
        model(11'd123, 1'b1);
        check("model_123_stream", pack_q(), 32'h000A123E);
        check("model_123_digits", m_dig, 16'h0123);
        model(11'h400, 1'b1);
        check("model_m1024_stream", pack_q(), 32'h00B1024E);
        check("model_m1024_neg", m_neg, 1);
        model(11'd0, 1'b1);
        check("model_0_stream", pack_q(), 32'h00000A0E);
        model(11'd500, 1'b0);
        check("model_500_nosup", pack_q(), 32'h00A0500E);
        model(11'h7F9, 1'b1);
        check("model_m7_stream", pack_q(), 32'h00000B7E);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        code_ready = 1'b1;

        launch(11'd0);
        finish_wait("zero");

        launch(11'd123);
        finish_wait("v123");
        check("v123_digits_lit", dig0, 16'h0123);

        launch(11'h400);
        finish_wait("m1024");
        check("m1024_digits_lit", dig0, 16'h1024);
        check("m1024_neg_lit", neg0, 1);

        // Consumer stalls for 5 cycles after done.
        code_ready = 1'b0;
        launch(11'h7F9);
        k = 0;
        while (!done0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("m7_done_wait", (k < 30), 1);
        repeat (6) @(posedge clk);
        #1 code_ready = 1'b1;
        finish_wait("m7");

        // Second start while busy must be ignored.
        launch(11'd500);
        repeat (2) @(posedge clk);
        #1;
        data_in = 11'd77;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_wait("v500");
        check("v500_digits_lit", dig0, 16'h0500);
        check("v500_digits1_lit", dig1, 16'h0500);

        // Reset mid-conversion.
        launch(11'd999);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("midreset");
        #2 rst = 1'b0;
        clear_state();
        repeat (20) @(posedge clk);
        #1;
        check("postreset_idle", {busy1, busy0, valid1, valid0}, 0);
        check("postreset_digits", dig0, 16'h0000);

        launch(11'd42);
        finish_wait("v42");
        check("v42_digits_lit", dig0, 16'h0042);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
